mem_stage_sramlike: RTL and testbench

Parametrised LoongArch memory-access pipeline stage between EX and WB, for a data bus with split request/response (`data_ok`) handshake. It holds one instruction, waits for its load/store response, and extracts and extends load data for any naturally aligned width up to `XLEN`. It forwards the result and load-use blocking to ID, and tracks responses still owed to flushed instructions so that stale data is discarded.

---
 rtl/mem_stage_sramlike_pkg.sv | 22 ++
 rtl/mem_stage_sramlike_if.sv | 55 +++++
 rtl/mem_stage_sramlike_load_extract.sv | 27 ++
 rtl/mem_stage_sramlike.sv | 135 +++++++++++++
 tb/tb_mem_stage_sramlike.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_sramlike_pkg.sv
// Shared constants and types for the MEM stage with split request/response data bus.
// ld_op is one-hot, MSB first: {ld_b, ld_bu, ld_h, ld_hu, ld_w, ld_wu, ld_d}.
package mem_stage_sramlike_pkg;

  localparam int LD_OP_W   = 7;
  localparam int LD_B      = 6;
  localparam int LD_BU     = 5;
  localparam int LD_H      = 4;
  localparam int LD_HU     = 3;
  localparam int LD_W      = 2;
  localparam int LD_WU     = 1;
  localparam int LD_D      = 0;

  localparam int EXC_W_DEF = 85;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } slot_state_e;

endpackage

// File: rtl/mem_stage_sramlike_if.sv
// Signal bundle around the MEM stage: EX offer, WB hand-off, data bus response, ID forwarding, flush.
// slave is the stage's own view; master is the surrounding pipeline's view.
interface mem_stage_sramlike_if
  import mem_stage_sramlike_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int EXC_W = EXC_W_DEF
);
  logic               es2ms_valid;
  logic               ms_allowin;
  logic               es2ms_mem_req;
  logic [LD_OP_W-1:0] es2ms_ld_op;
  logic               es2ms_res_from_mem;
  logic               es2ms_rf_we;
  logic [4:0]         es2ms_rf_waddr;
  logic [XLEN-1:0]    es2ms_result;
  logic [31:0]        es2ms_pc;
  logic [EXC_W-1:0]   es2ms_exc;
  logic               es_req_inflight;
  logic               data_sram_data_ok;
  logic [XLEN-1:0]    data_sram_rdata;
  logic               ws_allowin;
  logic               ms2ws_valid;
  logic [31:0]        ms2ws_pc;
  logic [XLEN-1:0]    ms2ws_result;
  logic [EXC_W-1:0]   ms2ws_exc;
  logic               ms2ws_rf_we;
  logic [4:0]         ms2ws_rf_waddr;
  logic               ms_fwd_we;
  logic [4:0]         ms_fwd_waddr;
  logic [XLEN-1:0]    ms_fwd_wdata;
  logic               ms_fwd_stall;
  logic               ms_ex;
  logic               wb_flush;
  logic               ms_drop_busy;

  modport slave (
    input  es2ms_valid, es2ms_mem_req, es2ms_ld_op, es2ms_res_from_mem, es2ms_rf_we,
           es2ms_rf_waddr, es2ms_result, es2ms_pc, es2ms_exc, es_req_inflight,
           data_sram_data_ok, data_sram_rdata, ws_allowin, wb_flush,
    output ms_allowin, ms2ws_valid, ms2ws_pc, ms2ws_result, ms2ws_exc, ms2ws_rf_we,
           ms2ws_rf_waddr, ms_fwd_we, ms_fwd_waddr, ms_fwd_wdata, ms_fwd_stall, ms_ex,
           ms_drop_busy
  );

  modport master (
    output es2ms_valid, es2ms_mem_req, es2ms_ld_op, es2ms_res_from_mem, es2ms_rf_we,
           es2ms_rf_waddr, es2ms_result, es2ms_pc, es2ms_exc, es_req_inflight,
           data_sram_data_ok, data_sram_rdata, ws_allowin, wb_flush,
    input  ms_allowin, ms2ws_valid, ms2ws_pc, ms2ws_result, ms2ws_exc, ms2ws_rf_we,
           ms2ws_rf_waddr, ms_fwd_we, ms_fwd_waddr, ms_fwd_wdata, ms_fwd_stall, ms_ex,
           ms_drop_busy
  );

endinterface

// File: rtl/mem_stage_sramlike_load_extract.sv
// Load data alignment: shift the bus word down by the byte offset, then sign/zero extend.
module load_extract
  import mem_stage_sramlike_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = $clog2(XLEN / 8)
) (
  input  logic [LD_OP_W-1:0] ld_op,
  input  logic [OFF_W-1:0]   off,
  input  logic [XLEN-1:0]    rdata,
  output logic [XLEN-1:0]    data
);
  logic [XLEN-1:0] sh;

  always_comb begin
    sh   = rdata >> {off, 3'b000};
    data = sh;
    // Size casts on signed slices sign-extend; at XLEN=32 the word cases collapse to identity.
    if      (ld_op[LD_B])  data = XLEN'($signed(sh[7:0]));
    else if (ld_op[LD_BU]) data = XLEN'(sh[7:0]);
    else if (ld_op[LD_H])  data = XLEN'($signed(sh[15:0]));
    else if (ld_op[LD_HU]) data = XLEN'(sh[15:0]);
    else if (ld_op[LD_W])  data = XLEN'($signed(sh[31:0]));
    else if (ld_op[LD_WU]) data = XLEN'(sh[31:0]);
  end

endmodule

// File: rtl/mem_stage_sramlike.sv
// MEM pipeline stage: one-instruction slot waiting on data_ok, load extraction, forwarding to ID,
// and a drop counter for bus responses still owed to flushed instructions.
//
// state   | meaning
// S_EMPTY | no instruction held
// S_WAIT  | request outstanding, response not yet seen
// S_HOLD  | response captured in rdata_buf, or no request owed
module mem_stage_sramlike
  import mem_stage_sramlike_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int EXC_W    = EXC_W_DEF,
  parameter int MAX_OUTS = 2
) (
  input logic                 clk,
  input logic                 reset,
  mem_stage_sramlike_if.slave bus
);
  localparam int OFF_W = $clog2(XLEN / 8);
  localparam int CNT_W = $clog2(MAX_OUTS + 1);

  slot_state_e        state, state_nx;
  logic [CNT_W-1:0]   drop_cnt, drop_nx;
  logic [CNT_W:0]     drop_sum;
  logic [31:0]        pc_q;
  logic [XLEN-1:0]    result_q, rdata_buf, ld_src, ld_data, res_out;
  logic [EXC_W-1:0]   exc_q;
  logic               rf_we_q, res_from_mem_q;
  logic [4:0]         waddr_q;
  logic [LD_OP_W-1:0] ld_op_q;
  logic               valid, ready_go, wait_hit, drop_now, owe_ms, allowin;
  logic               slot_load, buf_we;

  assign valid    = state != S_EMPTY;
  assign drop_now = bus.data_sram_data_ok && drop_cnt != '0;
  assign wait_hit = state == S_WAIT && bus.data_sram_data_ok && drop_cnt == '0;
  assign ready_go = state == S_HOLD || wait_hit;
  assign owe_ms   = state == S_WAIT && !wait_hit;
  assign allowin  = state == S_EMPTY || (ready_go && bus.ws_allowin);

  always_comb begin
    state_nx  = state;
    slot_load = 1'b0;
    buf_we    = 1'b0;
    if (bus.wb_flush) begin
      state_nx = S_EMPTY;
    end else if (allowin) begin
      if (bus.es2ms_valid) begin
        state_nx  = bus.es2ms_mem_req ? S_WAIT : S_HOLD;
        slot_load = 1'b1;
      end else begin
        state_nx  = S_EMPTY;
      end
    end else if (wait_hit) begin
      state_nx = S_HOLD;
      buf_we   = 1'b1;
    end
  end

  // A data_ok in the flush cycle either pays an older drop or satisfies this slot's own request.
  always_comb begin
    drop_sum = {1'b0, drop_cnt} + (CNT_W+1)'(owe_ms) + (CNT_W+1)'(bus.es_req_inflight)
               - (CNT_W+1)'(drop_now);
    drop_nx  = drop_cnt;
    if (bus.wb_flush) begin
      drop_nx = (drop_sum > (CNT_W+1)'(MAX_OUTS)) ? CNT_W'(MAX_OUTS) : drop_sum[CNT_W-1:0];
    end else if (drop_now) begin
      drop_nx = drop_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_EMPTY;
      drop_cnt <= '0;
    end else begin
      state    <= state_nx;
      drop_cnt <= drop_nx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q           <= '0;
      result_q       <= '0;
      exc_q          <= '0;
      rf_we_q        <= 1'b0;
      res_from_mem_q <= 1'b0;
      waddr_q        <= '0;
      ld_op_q        <= '0;
      rdata_buf      <= '0;
    end else begin
      if (slot_load) begin
        pc_q           <= bus.es2ms_pc;
        result_q       <= bus.es2ms_result;
        exc_q          <= bus.es2ms_exc;
        rf_we_q        <= bus.es2ms_rf_we;
        res_from_mem_q <= bus.es2ms_res_from_mem;
        waddr_q        <= bus.es2ms_rf_waddr;
        ld_op_q        <= bus.es2ms_ld_op;
      end
      if (buf_we) rdata_buf <= bus.data_sram_rdata;
    end
  end

  assign ld_src = (state == S_HOLD) ? rdata_buf : bus.data_sram_rdata;

  load_extract #(.XLEN(XLEN)) u_load_extract (
    .ld_op (ld_op_q),
    .off   (result_q[OFF_W-1:0]),
    .rdata (ld_src),
    .data  (ld_data)
  );

  assign res_out = res_from_mem_q ? ld_data : result_q;

  assign bus.ms_allowin     = allowin;
  assign bus.ms2ws_valid    = valid && ready_go && !bus.wb_flush;
  assign bus.ms2ws_pc       = pc_q;
  assign bus.ms2ws_result   = res_out;
  assign bus.ms2ws_exc      = exc_q;
  assign bus.ms2ws_rf_we    = rf_we_q;
  assign bus.ms2ws_rf_waddr = waddr_q;
  assign bus.ms_fwd_we      = valid && rf_we_q;
  assign bus.ms_fwd_waddr   = waddr_q;
  assign bus.ms_fwd_wdata   = res_out;
  assign bus.ms_fwd_stall   = valid && res_from_mem_q && !ready_go;
  assign bus.ms_ex          = valid && (exc_q != '0);
  assign bus.ms_drop_busy   = drop_cnt != '0;

  // More owed responses than the counter can track means the bus protocol was broken upstream.
  assert property (@(posedge clk) disable iff (reset)
    !(bus.wb_flush && drop_sum > (CNT_W+1)'(MAX_OUTS)));

endmodule

// File: tb/tb_mem_stage_sramlike.sv
// Bench for mem_stage_sramlike: 32- and 64-bit instances, expected WB results queued on issue
// and compared by negedge monitors when the stage hands an instruction to WB.
module tb_mem_stage_sramlike;
  import mem_stage_sramlike_pkg::*;

  typedef struct packed {
    logic [63:0] res;
    logic [31:0] pc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  int   dlv32 = 0;
  int   dlv64 = 0;
  exp_t sb32[$];
  exp_t sb64[$];
  exp_t e32, e64;

  localparam logic [LD_OP_W-1:0] OP_B  = 7'b1000000;
  localparam logic [LD_OP_W-1:0] OP_HU = 7'b0001000;
  localparam logic [LD_OP_W-1:0] OP_H  = 7'b0010000;
  localparam logic [LD_OP_W-1:0] OP_W  = 7'b0000100;
  localparam logic [LD_OP_W-1:0] OP_WU = 7'b0000010;
  localparam logic [LD_OP_W-1:0] OP_D  = 7'b0000001;

  mem_stage_sramlike_if #(.XLEN(32), .EXC_W(EXC_W_DEF)) if32 ();
  mem_stage_sramlike_if #(.XLEN(64), .EXC_W(EXC_W_DEF)) if64 ();

  mem_stage_sramlike #(.XLEN(32), .EXC_W(EXC_W_DEF), .MAX_OUTS(2)) dut32 (
    .clk(clk), .reset(reset), .bus(if32));
  mem_stage_sramlike #(.XLEN(64), .EXC_W(EXC_W_DEF), .MAX_OUTS(2)) dut64 (
    .clk(clk), .reset(reset), .bus(if64));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer32(input logic [LD_OP_W-1:0] op, input logic req, input logic rfm,
                         input logic [31:0] res, input logic [31:0] pc, input logic exc0);
    if32.es2ms_valid        = 1'b1;
    if32.es2ms_mem_req      = req;
    if32.es2ms_ld_op        = op;
    if32.es2ms_res_from_mem = rfm;
    if32.es2ms_rf_we        = 1'b1;
    if32.es2ms_rf_waddr     = 5'd5;
    if32.es2ms_result       = res;
    if32.es2ms_pc           = pc;
    if32.es2ms_exc          = EXC_W_DEF'(exc0);
  endtask

  task automatic load64(input logic [LD_OP_W-1:0] op, input logic [63:0] addr,
                        input logic [63:0] rdata, input logic [31:0] pc,
                        input logic [63:0] exp);
    tick();
    if64.es2ms_valid        = 1'b1;
    if64.es2ms_mem_req      = 1'b1;
    if64.es2ms_ld_op        = op;
    if64.es2ms_res_from_mem = 1'b1;
    if64.es2ms_rf_we        = 1'b1;
    if64.es2ms_rf_waddr     = 5'd9;
    if64.es2ms_result       = addr;
    if64.es2ms_pc           = pc;
    if64.es2ms_exc          = '0;
    sb64.push_back('{exp, pc});
    tick();
    if64.es2ms_valid       = 1'b0;
    if64.data_sram_data_ok = 1'b1;
    if64.data_sram_rdata   = rdata;
    @(negedge clk);
    chk("ld64_valid", 64'(if64.ms2ws_valid), 64'd1);
    tick();
    if64.data_sram_data_ok = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && if32.ms2ws_valid && if32.ws_allowin) begin
      if (sb32.size() == 0) chk("unexp32", 64'(if32.ms2ws_valid), 64'd0);
      else begin
        e32 = sb32.pop_front();
        chk("res32", 64'(if32.ms2ws_result), e32.res);
        chk("pc32", 64'(if32.ms2ws_pc), 64'(e32.pc));
        dlv32++;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && if64.ms2ws_valid && if64.ws_allowin) begin
      if (sb64.size() == 0) chk("unexp64", 64'(if64.ms2ws_valid), 64'd0);
      else begin
        e64 = sb64.pop_front();
        chk("res64", if64.ms2ws_result, e64.res);
        chk("pc64", 64'(if64.ms2ws_pc), 64'(e64.pc));
        dlv64++;
      end
    end
  end

  initial begin
    if32.es2ms_valid = 0; if32.es2ms_mem_req = 0; if32.es2ms_ld_op = '0;
    if32.es2ms_res_from_mem = 0; if32.es2ms_rf_we = 0; if32.es2ms_rf_waddr = '0;
    if32.es2ms_result = '0; if32.es2ms_pc = '0; if32.es2ms_exc = '0;
    if32.es_req_inflight = 0; if32.data_sram_data_ok = 0; if32.data_sram_rdata = '0;
    if32.ws_allowin = 1; if32.wb_flush = 0;
    if64.es2ms_valid = 0; if64.es2ms_mem_req = 0; if64.es2ms_ld_op = '0;
    if64.es2ms_res_from_mem = 0; if64.es2ms_rf_we = 0; if64.es2ms_rf_waddr = '0;
    if64.es2ms_result = '0; if64.es2ms_pc = '0; if64.es2ms_exc = '0;
    if64.es_req_inflight = 0; if64.data_sram_data_ok = 0; if64.data_sram_rdata = '0;
    if64.ws_allowin = 1; if64.wb_flush = 0;

    repeat (2) tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_allowin", 64'(if32.ms_allowin), 64'd1);
    chk("rst_valid", 64'(if32.ms2ws_valid), 64'd0);
    chk("rst_busy", 64'(if32.ms_drop_busy), 64'd0);
    chk("rst_stall", 64'(if32.ms_fwd_stall), 64'd0);
    chk("rst_fwd_we", 64'(if32.ms_fwd_we), 64'd0);
    chk("rst_result", 64'(if32.ms2ws_result), 64'd0);
    chk("rst_allowin64", 64'(if64.ms_allowin), 64'd1);

    // ld_b, offset 3, data_ok two cycles after entry
    tick(); offer32(OP_B, 1, 1, 32'h1000_0003, 32'h100, 0);
    sb32.push_back('{64'hFFFF_FF80, 32'h100});
    @(negedge clk); chk("ldb_allowin", 64'(if32.ms_allowin), 64'd1);
    for (int i = 0; i < 2; i++) begin
      tick(); if32.es2ms_valid = 0;
      @(negedge clk);
      chk("ldb_stall", 64'(if32.ms_fwd_stall), 64'd1);
      chk("ldb_novalid", 64'(if32.ms2ws_valid), 64'd0);
    end
    tick(); if32.data_sram_data_ok = 1; if32.data_sram_rdata = 32'h8012_3456;
    @(negedge clk);
    chk("ldb_valid", 64'(if32.ms2ws_valid), 64'd1);
    chk("ldb_stall_off", 64'(if32.ms_fwd_stall), 64'd0);
    chk("ldb_fwd_data", 64'(if32.ms_fwd_wdata), 64'hFFFF_FF80);
    chk("ldb_fwd_we", 64'(if32.ms_fwd_we), 64'd1);
    tick(); if32.data_sram_data_ok = 0;
    @(negedge clk);
    chk("ldb_empty", 64'(if32.ms_allowin), 64'd1);
    chk("ldb_done", 64'(if32.ms2ws_valid), 64'd0);

    // ld_hu, offset 2, WB stalls in the data_ok cycle and three more
    tick(); offer32(OP_HU, 1, 1, 32'h0000_2002, 32'h200, 0);
    sb32.push_back('{64'h0000_BEEF, 32'h200});
    tick(); if32.es2ms_valid = 0; if32.data_sram_data_ok = 1;
    if32.data_sram_rdata = 32'hBEEF_0000; if32.ws_allowin = 0;
    @(negedge clk); chk("hu_allowin0", 64'(if32.ms_allowin), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick(); if32.data_sram_data_ok = 0; if32.data_sram_rdata = 32'h1111_1111;
      @(negedge clk);
      chk("hu_hold_allowin", 64'(if32.ms_allowin), 64'd0);
      chk("hu_hold_data", 64'(if32.ms_fwd_wdata), 64'h0000_BEEF);
      chk("hu_hold_stall", 64'(if32.ms_fwd_stall), 64'd0);
    end
    tick(); if32.ws_allowin = 1;
    @(negedge clk); chk("hu_valid", 64'(if32.ms2ws_valid), 64'd1);
    tick();
    @(negedge clk); chk("hu_once", 64'(if32.ms2ws_valid), 64'd0);

    // flush in WAIT with a request also in flight in EX
    tick(); offer32(OP_W, 1, 1, 32'h0000_3000, 32'h300, 0);
    tick(); if32.es2ms_valid = 0; if32.wb_flush = 1; if32.es_req_inflight = 1;
    @(negedge clk); chk("fl_novalid", 64'(if32.ms2ws_valid), 64'd0);
    tick(); if32.wb_flush = 0; if32.es_req_inflight = 0;
    @(negedge clk);
    chk("fl_busy", 64'(if32.ms_drop_busy), 64'd1);
    chk("fl_allowin", 64'(if32.ms_allowin), 64'd1);
    for (int i = 0; i < 2; i++) begin
      tick(); if32.data_sram_data_ok = 1; if32.data_sram_rdata = 32'hDEAD_BEEF;
      @(negedge clk); chk("fl_drop_busy", 64'(if32.ms_drop_busy), 64'd1);
    end
    tick(); if32.data_sram_data_ok = 0;
    @(negedge clk); chk("fl_busy_clear", 64'(if32.ms_drop_busy), 64'd0);
    tick(); offer32(OP_W, 1, 1, 32'h0000_3004, 32'h304, 0);
    sb32.push_back('{64'h1234_5678, 32'h304});
    tick(); if32.es2ms_valid = 0; if32.data_sram_data_ok = 1;
    if32.data_sram_rdata = 32'h1234_5678;
    @(negedge clk); chk("fl_ldw_valid", 64'(if32.ms2ws_valid), 64'd1);
    tick(); if32.data_sram_data_ok = 0;

    // flush in the same cycle as the slot's own data_ok
    tick(); offer32(OP_W, 1, 1, 32'h0000_4000, 32'h400, 0);
    tick(); if32.es2ms_valid = 0; if32.wb_flush = 1; if32.data_sram_data_ok = 1;
    if32.data_sram_rdata = 32'hCAFE_F00D;
    @(negedge clk); chk("fd_novalid", 64'(if32.ms2ws_valid), 64'd0);
    tick(); if32.wb_flush = 0; if32.data_sram_data_ok = 0;
    @(negedge clk);
    chk("fd_busy", 64'(if32.ms_drop_busy), 64'd0);
    chk("fd_allowin", 64'(if32.ms_allowin), 64'd1);

    // non-memory instruction carrying an exception
    tick(); offer32('0, 0, 0, 32'hABCD_0001, 32'h500, 1);
    sb32.push_back('{64'hABCD_0001, 32'h500});
    tick(); if32.es2ms_valid = 0;
    @(negedge clk);
    chk("ex_flag", 64'(if32.ms_ex), 64'd1);
    chk("ex_valid", 64'(if32.ms2ws_valid), 64'd1);
    chk("ex_exc0", 64'(if32.ms2ws_exc[0]), 64'd1);
    chk("ex_busy", 64'(if32.ms_drop_busy), 64'd0);
    tick();
    @(negedge clk); chk("ex_after", 64'(if32.ms_ex), 64'd0);

    // 64-bit datapath
    load64(OP_WU, 64'h4, 64'h89AB_CDEF_0000_0000, 32'h600, 64'h0000_0000_89AB_CDEF);
    load64(OP_W,  64'h4, 64'h89AB_CDEF_0000_0000, 32'h604, 64'hFFFF_FFFF_89AB_CDEF);
    load64(OP_D,  64'h0, 64'h0123_4567_89AB_CDEF, 32'h608, 64'h0123_4567_89AB_CDEF);
    load64(OP_H,  64'h6, 64'h8001_0000_0000_0000, 32'h60C, 64'hFFFF_FFFF_FFFF_8001);

    tick();
    @(negedge clk);
    chk("sb32_left", 64'(sb32.size()), 64'd0);
    chk("sb64_left", 64'(sb64.size()), 64'd0);
    chk("dlv32", 64'(dlv32), 64'd4);
    chk("dlv64", 64'(dlv64), 64'd4);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
